// File: rtl/mem_req_scheduler.sv
// Round-robin scheduler sharing one memory_controller port among icache (0), dcache (1) and ptw (2).
// One transaction in flight at a time, with a per-transaction watchdog and a dcache invalidate forward.
module mem_req_scheduler #(
  parameter int ADDR_W  = 64,
  parameter int BLOCK_W = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         req,
  input  logic [ADDR_W-1:0]  ic_addr,
  input  logic [ADDR_W-1:0]  dc_addr,
  input  logic               dc_wr_en,
  input  logic [BLOCK_W-1:0] dc_wdata,
  input  logic [ADDR_W-1:0]  ptw_addr,
  output logic [2:0]         done,
  output logic               resp_err,
  output logic [BLOCK_W-1:0] resp_data,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_wr_en,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_data_in,
  input  logic               mem_data_valid,
  input  logic               inv_in,
  input  logic [ADDR_W-1:0]  inv_addr_in,
  output logic               dc_inv,
  output logic [ADDR_W-1:0]  dc_inv_addr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state;
  logic [1:0]              rr_ptr;
  logic [1:0]              grant;
  logic [CNT_W-1:0]        cnt;
  logic [2:0][ADDR_W-1:0]  req_addr;
  logic [1:0]              pick;
  logic                    found;
  logic [2:0]              cand;

  assign req_addr = {ptw_addr, dc_addr, ic_addr};

  // First requester at or after rr_ptr, wrapping modulo 3.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    cand  = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && req[cand[1:0]]) begin
        pick  = cand[1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      grant       <= 2'd0;
      cnt         <= '0;
      done        <= 3'b000;
      resp_err    <= 1'b0;
      resp_data   <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wdata   <= '0;
      dc_inv      <= 1'b0;
      dc_inv_addr <= '0;
    end else begin
      dc_inv      <= inv_in;
      dc_inv_addr <= inv_addr_in;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant     <= pick;
            mem_addr  <= req_addr[pick];
            mem_wr_en <= (pick == 2'd1) && dc_wr_en;
            mem_wdata <= (pick == 2'd1) ? dc_wdata : '0;
            mem_req   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_req <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (mem_data_valid) begin
            resp_data <= mem_data_in;
            resp_err  <= 1'b0;
            done      <= 3'b001 << grant;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            done      <= 3'b001 << grant;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done      <= 3'b000;
          resp_err  <= 1'b0;
          resp_data <= '0;
          rr_ptr    <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: single reads, round-robin, write-back, timeout, reset, invalidate.
module tb_mem_req_scheduler;
  localparam int ADDR_W  = 64;
  localparam int BLOCK_W = 512;
  localparam int TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [2:0]         req = '0;
  logic [ADDR_W-1:0]  ic_addr = 64'h1000;
  logic [ADDR_W-1:0]  dc_addr = 64'h2040;
  logic               dc_wr_en = 1'b0;
  logic [BLOCK_W-1:0] dc_wdata = '0;
  logic [ADDR_W-1:0]  ptw_addr = 64'h5000;
  logic [2:0]         done;
  logic               resp_err;
  logic [BLOCK_W-1:0] resp_data;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_wr_en;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_data_in = '0;
  logic               mem_data_valid = 1'b0;
  logic               inv_in = 1'b0;
  logic [ADDR_W-1:0]  inv_addr_in = '0;
  logic               dc_inv;
  logic [ADDR_W-1:0]  dc_inv_addr;

  int n_chk  = 0;
  int n_fail = 0;
  int n_mreq = 0;

  logic [BLOCK_W-1:0] pat_a5, d0, d1, d2;

  mem_req_scheduler #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .ic_addr(ic_addr), .dc_addr(dc_addr), .dc_wr_en(dc_wr_en), .dc_wdata(dc_wdata),
    .ptw_addr(ptw_addr),
    .done(done), .resp_err(resp_err), .resp_data(resp_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .inv_in(inv_in), .inv_addr_in(inv_addr_in),
    .dc_inv(dc_inv), .dc_inv_addr(dc_inv_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req) n_mreq <= n_mreq + 1;

  task automatic chk(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_mreq", 512'(mem_req), 512'(0));
    chk("rst_maddr", 512'(mem_addr), 512'(0));
    chk("rst_wdata", mem_wdata, 512'(0));
    chk("rst_rdata", resp_data, 512'(0));
    chk("rst_dcinv", 512'(dc_inv), 512'(0));
    rst = 1'b0;
  endtask

  // Called in an IDLE cycle with req already driven; returns in the IDLE cycle after DONE.
  task automatic run_txn(input string tag, input logic [2:0] exp_done, input logic [ADDR_W-1:0] exp_addr,
                         input logic exp_wr, input logic [BLOCK_W-1:0] exp_wdata, input int lat,
                         input logic [BLOCK_W-1:0] rdata, input logic drop_req);
    tick();
    chk({tag, "_mreq1"}, 512'(mem_req), 512'(1));
    chk({tag, "_addr"}, 512'(mem_addr), 512'(exp_addr));
    chk({tag, "_wr"}, 512'(mem_wr_en), 512'(exp_wr));
    chk({tag, "_wdata"}, mem_wdata, exp_wdata);
    if (drop_req) req = 3'b000;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == 1) chk({tag, "_mreq0"}, 512'(mem_req), 512'(0));
      chk({tag, "_wait_done"}, 512'(done), 512'(0));
      if (exp_wr) chk({tag, "_wdata_hold"}, mem_wdata, exp_wdata);
      if (k == lat) begin
        mem_data_valid = 1'b1;
        mem_data_in    = rdata;
      end
    end
    tick();
    mem_data_valid = 1'b0;
    chk({tag, "_done"}, 512'(done), 512'(exp_done));
    chk({tag, "_err"}, 512'(resp_err), 512'(0));
    chk({tag, "_rdata"}, resp_data, rdata);
    tick();
    chk({tag, "_done_clr"}, 512'(done), 512'(0));
  endtask

  initial begin
    pat_a5 = {64{8'hA5}};
    d0 = {16{32'hDEADBEEF}};
    d1 = {16{32'h01234567}};
    d2 = {16{32'hCAFEF00D}};

    // reset state and single icache read, valid 3 cycles after mem_req
    do_reset();
    req = 3'b001;
    run_txn("ic1", 3'b001, 64'h1000, 1'b0, '0, 3, d0, 1'b1);
    chk("ic1_mreq_pulses", 512'(n_mreq), 512'(1));

    // round-robin with all requesters held
    do_reset();
    req = 3'b111;
    for (int r = 0; r < 2; r++) begin
      run_txn("rr_ic", 3'b001, 64'h1000, 1'b0, '0, 1, d0, 1'b0);
      run_txn("rr_dc", 3'b010, 64'h2040, 1'b0, '0, 1, d1, 1'b0);
      run_txn("rr_pt", 3'b100, 64'h5000, 1'b0, '0, 1, d2, 1'b0);
    end
    req = 3'b000;

    // dcache write-back
    dc_wr_en = 1'b1;
    dc_wdata = pat_a5;
    req = 3'b010;
    run_txn("wb", 3'b010, 64'h2040, 1'b1, pat_a5, 4, d1, 1'b1);
    dc_wr_en = 1'b0;

    // ptw timeout, late valid ignored, then normal service
    req = 3'b100;
    tick();
    chk("to_mreq", 512'(mem_req), 512'(1));
    req = 3'b000;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      chk("to_wait_done", 512'(done), 512'(0));
    end
    tick();
    chk("to_done", 512'(done), 512'(3'b100));
    chk("to_err", 512'(resp_err), 512'(1));
    mem_data_valid = 1'b1;
    mem_data_in = d2;
    tick();
    chk("to_late_done", 512'(done), 512'(0));
    chk("to_late_err", 512'(resp_err), 512'(0));
    tick();
    chk("to_late_done2", 512'(done), 512'(0));
    chk("to_late_mreq", 512'(mem_req), 512'(0));
    mem_data_valid = 1'b0;
    req = 3'b001;
    run_txn("to_next", 3'b001, 64'h1000, 1'b0, '0, 2, d0, 1'b1);

    // reset in WAIT with dcache granted
    dc_wr_en = 1'b1;
    req = 3'b010;
    tick();
    req = 3'b000;
    tick();
    tick();
    chk("mr_pre_addr", 512'(mem_addr), 512'(64'h2040));
    #2 rst = 1'b1;
    #1;
    chk("mr_mreq", 512'(mem_req), 512'(0));
    chk("mr_addr", 512'(mem_addr), 512'(0));
    chk("mr_wr", 512'(mem_wr_en), 512'(0));
    chk("mr_wdata", mem_wdata, 512'(0));
    chk("mr_done", 512'(done), 512'(0));
    tick();
    chk("mr_done2", 512'(done), 512'(0));
    dc_wr_en = 1'b0;
    req = 3'b011;
    rst = 1'b0;
    run_txn("mr_rr", 3'b001, 64'h1000, 1'b0, '0, 1, d0, 1'b1);

    // invalidate forward during WAIT
    req = 3'b001;
    tick();
    req = 3'b000;
    tick();
    inv_in = 1'b1;
    inv_addr_in = 64'h3000;
    chk("inv_pre", 512'(dc_inv), 512'(0));
    tick();
    chk("inv_pulse", 512'(dc_inv), 512'(1));
    chk("inv_addr", 512'(dc_inv_addr), 512'(64'h3000));
    inv_in = 1'b0;
    mem_data_valid = 1'b1;
    mem_data_in = d2;
    tick();
    mem_data_valid = 1'b0;
    chk("inv_clr", 512'(dc_inv), 512'(0));
    chk("inv_txn_done", 512'(done), 512'(3'b001));
    chk("inv_txn_data", resp_data, d2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
